cook_timer_sequencer: RTL and testbench
=======================================

// Module: cook_timer_sequencer
// PURPOSE
//  Single-clock controller that sequences the microwave countdown datapath: latch set time, load, run, pause, done-flash.
//  Replaces multi-clock state handling with one clk domain and tick enables from the clock-divider blocks.
//  Sits between Debounce outputs and Display_8Bit; drives the display value and the done LED.
// PARAMETERS
//  WIDTH         8   width of set time / countdown value (seconds, unsigned binary)
//  FLASH_TICKS   50  number of flash_tick strobes spent in DONE before auto-return to LOADED
// PORTS
//  clk         in   1      system clock; sole clock
//  rst_n       in   1      synchronous reset, active-low
//  btn_start   in   1      debounced start/pause level (BTNR path)
//  btn_clear   in   1      debounced clear level (BTNL path)
//  sec_tick    in   1      1-cycle enable strobe, 1 Hz, from divider
//  flash_tick  in   1      1-cycle enable strobe, ~10 Hz, from divider
//  sw_time     in   WIDTH  switch-entered cook time
//  disp_val    out  WIDTH  value for Display_8Bit
//  disp_blank  out  1      1 = display shows EMPTY
//  done_led    out  1      flashing done indicator
//  state_o     out  3      current state encoding (debug / LEDs)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=SET, set_time=0, count=0, flash_cnt=0, done_led=0;
//   button edge-detect history regs reset to 1 (button held through reset does not fire).
//  Edge detect: start_p = btn_start & ~start_q; clear_p likewise; 1 cycle from level rise to pulse.
//  State takes effect on the posedge where the pulse/tick is high; outputs decode from registered state/count
//   (disp_val, disp_blank, state_o combinational from regs; done_led registered).
//  States (state_o): SET=000, LOADED=001, RUNNING=010, PAUSED=011, DONE=100.
//  clear_p: from any state -> SET, count=0, flash_cnt=0, done_led=0; overrides start_p and ticks same cycle.
//  SET: disp_blank=1, disp_val=0. start_p -> LOADED, set_time<=sw_time (captured that edge, 0 allowed).
//  LOADED: count<=set_time every cycle; disp_val=set_time. start_p and set_time!=0 -> RUNNING;
//   start_p with set_time==0 ignored (stay LOADED).
//  RUNNING: disp_val=count. sec_tick -> count<=count-1; if count==1 at that tick -> DONE (count=0).
//   start_p -> PAUSED; start_p and sec_tick same cycle: pause wins, no decrement.
//  PAUSED: disp_val=count frozen; sec_tick ignored. start_p -> RUNNING (count unchanged).
//  DONE: disp_val=0. each flash_tick: done_led toggles, flash_cnt++; when flash_cnt==FLASH_TICKS-1 on a
//   flash_tick -> LOADED, flash_cnt=0, done_led=0. start_p in DONE -> LOADED immediately, done_led=0.
//  Arithmetic: count never decrements below 0 (count==0 in RUNNING unreachable; if forced, go DONE, no wrap).
//  sw_time changes outside SET have no effect. flash_cnt width = $clog2(FLASH_TICKS).
//  Illegal state encodings -> SET on next clk.
// STRUCTURE
//  timer_pkg: state localparams (S_SET..S_DONE), EMPTY_DISPLAY constant, state width.
//  Sub-module edge_pulse (rising-edge detector, sync reset-to-1 history), instantiated for start and clear.
//  Single registered FSM + count/set_time/flash_cnt datapath in this module.
// TESTING
//  Reset with btn_start held high -> state_o=000, disp_blank=1, no transition until button released and repressed.
//  sw_time=3, start, start, 3 sec_ticks -> disp_val 3,2,1,0; state_o 010 then 100 on the 3rd tick edge.
//  DONE with FLASH_TICKS=4: 4 flash_ticks -> done_led 1,0,1,0 then state_o=001, disp_val=3.
//  RUNNING at count=5, start_p and sec_tick same cycle -> state_o=011, count stays 5; ticks ignored until start.
//  sw_time=0, start, start -> remains LOADED (001); clear_p mid-RUNNING with tick -> 000, count=0, done_led=0.
//  rst_n low mid-RUNNING (count=7) -> next edge all outputs at reset values.

Source files
------------

// File: rtl/cook_timer_sequencer_pkg.sv
// Shared types and constants for the microwave cook-timer sequencer.
// State encodings double as the debug/LED value presented on state_o.
package cook_timer_sequencer_pkg;

    localparam int unsigned STATE_W         = 3;
    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_FLASH_TICKS = 50;
    localparam int unsigned EMPTY_DISPLAY   = 0;

    typedef enum logic [STATE_W-1:0] {
        S_SET     = 3'b000,
        S_LOADED  = 3'b001,
        S_RUNNING = 3'b010,
        S_PAUSED  = 3'b011,
        S_DONE    = 3'b100
    } state_t;

    // A single-tick flash phase still needs a 1-bit counter to stay legal.
    function automatic int unsigned flash_cnt_w(input int unsigned ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/cook_timer_sequencer_if.sv
// Control/display bundle between the debounce/divider front end and the display.
// The master side produces buttons, ticks and switch time; the slave is the sequencer.
interface cook_timer_sequencer_if
    import cook_timer_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic               btn_start;
    logic               btn_clear;
    logic               sec_tick;
    logic               flash_tick;
    logic [WIDTH-1:0]   sw_time;
    logic [WIDTH-1:0]   disp_val;
    logic               disp_blank;
    logic               done_led;
    logic [STATE_W-1:0] state_o;

    modport master (
        output btn_start,
        output btn_clear,
        output sec_tick,
        output flash_tick,
        output sw_time,
        input  disp_val,
        input  disp_blank,
        input  done_led,
        input  state_o
    );

    modport slave (
        input  btn_start,
        input  btn_clear,
        input  sec_tick,
        input  flash_tick,
        input  sw_time,
        output disp_val,
        output disp_blank,
        output done_led,
        output state_o
    );
endinterface

// File: rtl/cook_timer_sequencer_edge_pulse.sv
// Rising-edge detector for a debounced button level.
// History resets to 1 so a button held through reset never produces a pulse.
module cook_timer_sequencer_edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse_c
);
    logic level_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign pulse_c = level & ~level_q;
endmodule

// File: rtl/cook_timer_sequencer.sv
// Single-clock microwave countdown controller: set, load, run, pause and done-flash,
// advanced by divider tick enables and driving the 8-bit display and done LED.
module cook_timer_sequencer
    import cook_timer_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned FLASH_TICKS = DEF_FLASH_TICKS
) (
    input logic                   clk,
    input logic                   rst_n,
    cook_timer_sequencer_if.slave bus
);
    localparam int unsigned    FCW        = flash_cnt_w(FLASH_TICKS);
    localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_TICKS - 1);

    state_t           state;
    logic [WIDTH-1:0] set_time;
    logic [WIDTH-1:0] count;
    logic [FCW-1:0]   flash_cnt;
    logic             done_led;
    logic             start_p_c;
    logic             clear_p_c;
    logic [WIDTH-1:0] disp_val_c;
    logic             disp_blank_c;

    cook_timer_sequencer_edge_pulse u_start_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .level   (bus.btn_start),
        .pulse_c (start_p_c)
    );

    cook_timer_sequencer_edge_pulse u_clear_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .level   (bus.btn_clear),
        .pulse_c (clear_p_c)
    );

    // Sequencer state plus countdown datapath; clear outranks every other event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_SET;
            set_time  <= '0;
            count     <= '0;
            flash_cnt <= '0;
            done_led  <= 1'b0;
        end else if (clear_p_c) begin
            state     <= S_SET;
            count     <= '0;
            flash_cnt <= '0;
            done_led  <= 1'b0;
        end else begin
            case (state)
                S_SET: begin
                    if (start_p_c) begin
                        set_time <= bus.sw_time;
                        state    <= S_LOADED;
                    end
                end
                S_LOADED: begin
                    count <= set_time;
                    if (start_p_c && (set_time != '0)) begin
                        state <= S_RUNNING;
                    end
                end
                S_RUNNING: begin
                    // Pause beats a coincident second tick; the last second lands on zero.
                    if (start_p_c) begin
                        state <= S_PAUSED;
                    end else if (bus.sec_tick) begin
                        if (count <= WIDTH'(1)) begin
                            count     <= '0;
                            flash_cnt <= '0;
                            done_led  <= 1'b0;
                            state     <= S_DONE;
                        end else begin
                            count <= count - WIDTH'(1);
                        end
                    end
                end
                S_PAUSED: begin
                    if (start_p_c) begin
                        state <= S_RUNNING;
                    end
                end
                S_DONE: begin
                    if (start_p_c) begin
                        flash_cnt <= '0;
                        done_led  <= 1'b0;
                        state     <= S_LOADED;
                    end else if (bus.flash_tick) begin
                        if (flash_cnt == FLASH_LAST) begin
                            flash_cnt <= '0;
                            done_led  <= 1'b0;
                            state     <= S_LOADED;
                        end else begin
                            flash_cnt <= flash_cnt + FCW'(1);
                            done_led  <= ~done_led;
                        end
                    end
                end
                default: begin
                    count     <= '0;
                    flash_cnt <= '0;
                    done_led  <= 1'b0;
                    state     <= S_SET;
                end
            endcase
        end
    end

    // Display decode from registered state and count.
    always_comb begin
        disp_val_c   = WIDTH'(EMPTY_DISPLAY);
        disp_blank_c = 1'b0;
        case (state)
            S_SET:     disp_blank_c = 1'b1;
            S_LOADED:  disp_val_c   = set_time;
            S_RUNNING: disp_val_c   = count;
            S_PAUSED:  disp_val_c   = count;
            S_DONE:    disp_val_c   = WIDTH'(EMPTY_DISPLAY);
            default:   disp_blank_c = 1'b1;
        endcase
    end

    assign bus.disp_val   = disp_val_c;
    assign bus.disp_blank = disp_blank_c;
    assign bus.done_led   = done_led;
    assign bus.state_o    = state;
endmodule

// File: tb/tb_cook_timer_sequencer.sv
// Bench for cook_timer_sequencer: directed scenarios plus a randomized event stream
// checked against a transaction-level model of the timer rules.
module tb_cook_timer_sequencer;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned FT    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cook_timer_sequencer_if #(.WIDTH(WIDTH)) bus ();

    cook_timer_sequencer #(.WIDTH(WIDTH), .FLASH_TICKS(FT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [12:0] obs;
    assign obs = {bus.state_o, bus.disp_val, bus.disp_blank, bus.done_led};

    // Model: named phases, seconds remaining, number of flashes shown so far.
    typedef enum int {M_SET = 0, M_LOADED = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4} mphase_t;
    mphase_t ph;
    int  m_set, m_cnt, m_flash;
    bit  m_led, h_start, h_clear;

    function automatic void model_reset();
        ph = M_SET; m_set = 0; m_cnt = 0; m_flash = 0; m_led = 1'b0;
        h_start = 1'b1; h_clear = 1'b1;
    endfunction

    function automatic void model_step(input bit st, input bit cl, input bit sec, input bit fl, input int sw);
        if (cl) begin
            ph = M_SET; m_cnt = 0; m_flash = 0; m_led = 1'b0;
            return;
        end
        case (ph)
            M_SET:    if (st) begin ph = M_LOADED; m_set = sw; end
            M_LOADED: begin
                m_cnt = m_set;
                if (st && m_set != 0) ph = M_RUN;
            end
            M_RUN: begin
                if (st) ph = M_PAUSE;
                else if (sec) begin
                    m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
                    if (m_cnt == 0) begin ph = M_DONE; m_flash = 0; m_led = 1'b0; end
                end
            end
            M_PAUSE:  if (st) ph = M_RUN;
            default: begin
                if (st) begin ph = M_LOADED; m_flash = 0; m_led = 1'b0; end
                else if (fl) begin
                    if (m_flash == FT - 1) begin ph = M_LOADED; m_flash = 0; m_led = 1'b0; end
                    else begin m_flash++; m_led = ~m_led; end
                end
            end
        endcase
    endfunction

    function automatic logic [12:0] model_obs();
        int dv;
        dv = (ph == M_SET || ph == M_DONE) ? 0 : (ph == M_LOADED) ? m_set : m_cnt;
        return {3'(ph), 8'(dv), (ph == M_SET), m_led};
    endfunction

    // One clock with the given levels; button presses are rising edges of the held level.
    task automatic step(input bit st, input bit cl, input bit sec, input bit fl, input int sw);
        bus.btn_start  = st;
        bus.btn_clear  = cl;
        bus.sec_tick   = sec;
        bus.flash_tick = fl;
        bus.sw_time    = WIDTH'(sw);
        @(posedge clk);
        model_step(st && !h_start, cl && !h_clear, sec, fl, sw);
        h_start = st;
        h_clear = cl;
        @(negedge clk);
        bus.sec_tick   = 1'b0;
        bus.flash_tick = 1'b0;
    endtask

    task automatic press(input int sw, input bit sec);
        step(1'b0, 1'b0, 1'b0, 1'b0, sw);
        step(1'b1, 1'b0, sec, 1'b0, sw);
    endtask

    task automatic do_clear();
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.btn_start = 1'b1; bus.btn_clear = 1'b0;
        bus.sec_tick = 1'b0; bus.flash_tick = 1'b0; bus.sw_time = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (obs !== {3'd0, 8'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_values act=%h exp=%h", obs, {3'd0, 8'd0, 1'b1, 1'b0});
        end
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 9);
        checks++;
        if (obs !== {3'd0, 8'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_held_button act=%h exp=%h", obs, {3'd0, 8'd0, 1'b1, 1'b0});
        end
        press(9, 1'b0);
        checks++;
        if (obs !== {3'd1, 8'd9, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_repress act=%h exp=%h", obs, {3'd1, 8'd9, 1'b0, 1'b0});
        end
    endtask

    task automatic test_countdown_and_flash();
        int exp_cnt;
        do_clear();
        press(3, 1'b0);
        press(0, 1'b0);
        checks++;
        if (obs !== {3'd2, 8'd3, 1'b0, 1'b0}) begin
            errors++; $display("FAIL run_start act=%h exp=%h", obs, {3'd2, 8'd3, 1'b0, 1'b0});
        end
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 0);
            exp_cnt = 3 - i;
            checks++;
            if (bus.disp_val !== 8'(exp_cnt) || bus.state_o !== ((i == 3) ? 3'd4 : 3'd2)) begin
                errors++;
                $display("FAIL countdown_tick%0d act=%0d/%0d exp=%0d/%0d", i, bus.disp_val,
                         bus.state_o, exp_cnt, (i == 3) ? 4 : 2);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 0);
            checks++;
            if (bus.done_led !== ((i % 2) == 1)) begin
                errors++; $display("FAIL flash_led%0d act=%b exp=%b", i, bus.done_led, (i % 2) == 1);
            end
        end
        checks++;
        if (obs !== {3'd1, 8'd3, 1'b0, 1'b0}) begin
            errors++; $display("FAIL flash_return act=%h exp=%h", obs, {3'd1, 8'd3, 1'b0, 1'b0});
        end
    endtask

    task automatic test_pause();
        do_clear();
        press(5, 1'b0);
        press(0, 1'b0);
        press(0, 1'b1);
        checks++;
        if (obs !== {3'd3, 8'd5, 1'b0, 1'b0}) begin
            errors++; $display("FAIL pause_wins act=%h exp=%h", obs, {3'd3, 8'd5, 1'b0, 1'b0});
        end
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 0);
        checks++;
        if (obs !== {3'd3, 8'd5, 1'b0, 1'b0}) begin
            errors++; $display("FAIL pause_frozen act=%h exp=%h", obs, {3'd3, 8'd5, 1'b0, 1'b0});
        end
        press(0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0);
        checks++;
        if (obs !== {3'd2, 8'd4, 1'b0, 1'b0}) begin
            errors++; $display("FAIL resume_tick act=%h exp=%h", obs, {3'd2, 8'd4, 1'b0, 1'b0});
        end
    endtask

    task automatic test_zero_and_clear();
        do_clear();
        press(0, 1'b0);
        press(7, 1'b0);
        checks++;
        if (obs !== {3'd1, 8'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL zero_time_stays act=%h exp=%h", obs, {3'd1, 8'd0, 1'b0, 1'b0});
        end
        do_clear();
        press(6, 1'b0);
        press(0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 0);
        checks++;
        if (obs !== {3'd0, 8'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL clear_mid_run act=%h exp=%h", obs, {3'd0, 8'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_reset_mid_run();
        do_clear();
        press(7, 1'b0);
        press(0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== {3'd0, 8'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_mid_run act=%h exp=%h", obs, {3'd0, 8'd0, 1'b1, 1'b0});
        end
        rst_n = 1'b1;
        model_reset();
        h_start = 1'b1;
    endtask

    task automatic test_random();
        bit st, cl, sec, fl;
        for (int i = 0; i < 600; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            cl  = ($urandom_range(0, 39) == 0);
            sec = ($urandom_range(0, 2) == 0);
            fl  = ($urandom_range(0, 1) == 0);
            step(st, cl, sec, fl, $urandom_range(0, 4));
            checks++;
            if (obs !== model_obs()) begin
                errors++; $display("FAIL random_step%0d act=%h exp=%h", i, obs, model_obs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown_and_flash();
        test_pause();
        test_zero_and_clear();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
